// File: rtl/rca_acc.sv
// rca_acc: frame accumulator with a valid/ready result handshake.
//
// Operand beats are summed into a C_ACC_W-bit accumulator. The frame ends on
// the beat that carries din_last. The frame sum, beat count and overflow flag
// are then registered onto dout/dout_cnt/dout_ovf. They are held with
// dout_vld=1 until the consumer takes them with dout_rdy. No new beats are
// accepted while a result is pending.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   clr                synchronous frame abort (drops any beat in the same cycle)
//   din/din_vld/din_last/din_rdy   operand stream
//   dout/dout_cnt/dout_ovf         frame sum, accepted beat count, overflow flag
//   dout_vld/dout_rdy              result handshake
//
// Build option:
//   RCA_ACC_SAT_EN  defined     -> the accumulator clamps to all-ones on carry-out
//                   undefined   -> the accumulator wraps modulo 2^C_ACC_W
//   dout_ovf reports carry-out in both builds.
//
// State | meaning
// IDLE  | waiting for the first beat of a frame
// ACC   | mid-frame, summing beats
// HOLD  | result presented on dout, waiting for dout_rdy
module rca_acc #(
  parameter int C_WIDTH = 16,
  parameter int C_ACC_W = 24,
  parameter int C_CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [C_WIDTH-1:0] din,
  input  logic               din_vld,
  input  logic               din_last,
  output logic               din_rdy,
  output logic [C_ACC_W-1:0] dout,
  output logic [C_CNT_W-1:0] dout_cnt,
  output logic               dout_ovf,
  output logic               dout_vld,
  input  logic               dout_rdy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [C_ACC_W-1:0] r_acc, w_acc_nxt, r_dout;
  logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt, r_dout_cnt;
  logic               r_ovf, w_ovf_nxt, r_dout_ovf, r_dout_vld;
  logic               w_beat, w_dout_ld;
  logic [C_ACC_W:0]   w_din_ext, w_sum;
  logic               w_carry;

  assign din_rdy   = (r_state != S_HOLD);
  assign w_beat    = din_vld & din_rdy & ~clr;
  assign w_din_ext = {{(C_ACC_W+1-C_WIDTH){1'b0}}, din};
  assign w_sum     = {1'b0, r_acc} + w_din_ext;
  assign w_carry   = w_sum[C_ACC_W];

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    w_dout_ld   = 1'b0;
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_beat) begin
            w_acc_nxt   = w_din_ext[C_ACC_W-1:0];
            w_cnt_nxt   = C_CNT_W'(1);
            w_ovf_nxt   = 1'b0;
            w_state_nxt = din_last ? S_HOLD : S_ACC;
            w_dout_ld   = din_last;
          end
        end
        S_ACC: begin
          if (w_beat) begin
`ifdef RCA_ACC_SAT_EN
            // Once clamped, every later add carries again or adds zero,
            // so the accumulator stays at all-ones for the rest of the frame.
            w_acc_nxt = w_carry ? {C_ACC_W{1'b1}} : w_sum[C_ACC_W-1:0];
`else
            w_acc_nxt = w_sum[C_ACC_W-1:0];
`endif
            w_cnt_nxt   = (r_cnt == {C_CNT_W{1'b1}}) ? r_cnt : r_cnt + C_CNT_W'(1);
            w_ovf_nxt   = r_ovf | w_carry;
            w_state_nxt = din_last ? S_HOLD : S_ACC;
            w_dout_ld   = din_last;
          end
        end
        S_HOLD: begin
          if (dout_rdy) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  // The result registers capture the next-state values at the edge that
  // accepts the last beat. That way dout is valid in the same cycle that
  // dout_vld rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout     <= '0;
      r_dout_cnt <= '0;
      r_dout_ovf <= 1'b0;
      r_dout_vld <= 1'b0;
    end else begin
      if (w_dout_ld) begin
        r_dout     <= w_acc_nxt;
        r_dout_cnt <= w_cnt_nxt;
        r_dout_ovf <= w_ovf_nxt;
      end
      if (clr)
        r_dout_vld <= 1'b0;
      else if (w_dout_ld)
        r_dout_vld <= 1'b1;
      else if ((r_state == S_HOLD) && dout_rdy)
        r_dout_vld <= 1'b0;
    end
  end

  assign dout     = r_dout;
  assign dout_cnt = r_dout_cnt;
  assign dout_ovf = r_dout_ovf;
  assign dout_vld = r_dout_vld;

endmodule

// File: tb/tb_rca_acc.sv
module tb_rca_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_checks = 0;
  int          n_errors = 0;

  // default-parameter instance
  logic        clr, din_vld, din_last, din_rdy, dout_ovf, dout_vld, dout_rdy;
  logic [15:0] din;
  logic [23:0] dout;
  logic [7:0]  dout_cnt;

  // narrow instance: 17-bit accumulator, 2-bit count
  logic        b_clr, b_vld, b_last, b_rdy_o, b_ovf, b_dvld, b_drdy;
  logic [15:0] b_din;
  logic [16:0] b_dout;
  logic [1:0]  b_cnt;

  always #5 clk = ~clk;

  rca_acc u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .din(din), .din_vld(din_vld), .din_last(din_last), .din_rdy(din_rdy),
    .dout(dout), .dout_cnt(dout_cnt), .dout_ovf(dout_ovf),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy)
  );

  rca_acc #(.C_WIDTH(16), .C_ACC_W(17), .C_CNT_W(2)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .clr(b_clr),
    .din(b_din), .din_vld(b_vld), .din_last(b_last), .din_rdy(b_rdy_o),
    .dout(b_dout), .dout_cnt(b_cnt), .dout_ovf(b_ovf),
    .dout_vld(b_dvld), .dout_rdy(b_drdy)
  );

  // Stimulus only: present one beat at a negedge and return at the next
  // negedge, after the intervening posedge has consumed it.
  task automatic beat(input logic [15:0] d, input logic last);
    din = d; din_vld = 1'b1; din_last = last;
    @(negedge clk);
  endtask

  task automatic b_beat(input logic [15:0] d, input logic last);
    b_din = d; b_vld = 1'b1; b_last = last;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_checks++; if (dout !== 24'h0) begin n_errors++; $display("FAIL reset_dout got %h exp %h", dout, 24'h0); end
    n_checks++; if (dout_cnt !== 8'h0) begin n_errors++; $display("FAIL reset_cnt got %h exp %h", dout_cnt, 8'h0); end
    n_checks++; if (dout_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b exp 0", dout_ovf); end
    n_checks++; if (dout_vld !== 1'b0) begin n_errors++; $display("FAIL reset_vld got %b exp 0", dout_vld); end
    n_checks++; if (din_rdy !== 1'b1) begin n_errors++; $display("FAIL reset_rdy got %b exp 1", din_rdy); end
    n_checks++; if (b_rdy_o !== 1'b1 || b_dvld !== 1'b0) begin n_errors++; $display("FAIL reset_b rdy %b vld %b exp 1 0", b_rdy_o, b_dvld); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sum;
    dout_rdy = 1'b1;  // ignored outside HOLD
    beat(16'h0001, 1'b0);
    beat(16'h0002, 1'b0);
    din_vld = 1'b0; din_last = 1'b1;  // last without valid must be ignored
    @(negedge clk);
    n_checks++; if (dout_vld !== 1'b0) begin n_errors++; $display("FAIL basic_last_ignored vld got %b exp 0", dout_vld); end
    beat(16'h0003, 1'b1);
    n_checks++; if (dout_vld !== 1'b1) begin n_errors++; $display("FAIL basic_vld got %b exp 1", dout_vld); end
    n_checks++; if (dout !== 24'h000006) begin n_errors++; $display("FAIL basic_dout got %h exp %h", dout, 24'h000006); end
    n_checks++; if (dout_cnt !== 8'd3) begin n_errors++; $display("FAIL basic_cnt got %0d exp 3", dout_cnt); end
    n_checks++; if (dout_ovf !== 1'b0) begin n_errors++; $display("FAIL basic_ovf got %b exp 0", dout_ovf); end
    n_checks++; if (din_rdy !== 1'b0) begin n_errors++; $display("FAIL basic_hold_rdy got %b exp 0", din_rdy); end
    din_vld = 1'b0; din_last = 1'b0;
    @(negedge clk);
    n_checks++; if (dout_vld !== 1'b0) begin n_errors++; $display("FAIL basic_vld_one_cycle got %b exp 0", dout_vld); end
  endtask

  task automatic test_single_beat;
    dout_rdy = 1'b1;
    beat(16'hFFFF, 1'b1);
    n_checks++; if (dout !== 24'h00FFFF) begin n_errors++; $display("FAIL single_dout got %h exp %h", dout, 24'h00FFFF); end
    n_checks++; if (dout_cnt !== 8'd1) begin n_errors++; $display("FAIL single_cnt got %0d exp 1", dout_cnt); end
    n_checks++; if (dout_ovf !== 1'b0 || dout_vld !== 1'b1) begin n_errors++; $display("FAIL single_flags ovf %b vld %b exp 0 1", dout_ovf, dout_vld); end
    din_vld = 1'b0; din_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overflow;
    logic [16:0] exp_a, exp_b;
`ifdef RCA_ACC_SAT_EN
    exp_a = 17'h1FFFF; exp_b = 17'h1FFFF;
`else
    exp_a = 17'h00000; exp_b = 17'h00001;
`endif
    b_beat(16'hFFFF, 1'b0);
    b_beat(16'hFFFF, 1'b0);
    b_beat(16'h0002, 1'b1);
    n_checks++; if (b_dout !== exp_a) begin n_errors++; $display("FAIL ovf_dout got %h exp %h", b_dout, exp_a); end
    n_checks++; if (b_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %b exp 1", b_ovf); end
    b_vld = 1'b0; b_last = 1'b0;
    @(negedge clk);
    // overflow stays set on later beats; the clamp also holds in the saturating build
    b_beat(16'hFFFF, 1'b0);
    b_beat(16'hFFFF, 1'b0);
    b_beat(16'h0002, 1'b0);
    b_beat(16'h0001, 1'b1);
    n_checks++; if (b_dout !== exp_b) begin n_errors++; $display("FAIL ovf_after_dout got %h exp %h", b_dout, exp_b); end
    n_checks++; if (b_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got %b exp 1", b_ovf); end
    b_vld = 1'b0; b_last = 1'b0;
    @(negedge clk);
    // count saturates at 3; a new frame clears overflow
    for (int i = 0; i < 4; i++) b_beat(16'h0001, 1'b0);
    b_beat(16'h0001, 1'b1);
    n_checks++; if (b_cnt !== 2'd3) begin n_errors++; $display("FAIL cnt_sat got %0d exp 3", b_cnt); end
    n_checks++; if (b_dout !== 17'h00005) begin n_errors++; $display("FAIL cnt_sat_dout got %h exp %h", b_dout, 17'h00005); end
    n_checks++; if (b_ovf !== 1'b0) begin n_errors++; $display("FAIL ovf_new_frame got %b exp 0", b_ovf); end
    b_vld = 1'b0; b_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_pressure;
    dout_rdy = 1'b0;
    beat(16'h0003, 1'b1);
    din = 16'h0009; din_vld = 1'b1; din_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (din_rdy !== 1'b0 || dout_vld !== 1'b1) begin n_errors++; $display("FAIL bp_hold[%0d] rdy %b vld %b exp 0 1", i, din_rdy, dout_vld); end
      n_checks++; if (dout !== 24'h000003 || dout_cnt !== 8'd1) begin n_errors++; $display("FAIL bp_stable[%0d] dout %h cnt %0d exp 000003 1", i, dout, dout_cnt); end
      @(negedge clk);
    end
    dout_rdy = 1'b1; din_last = 1'b1;
    @(negedge clk);
    n_checks++; if (dout_vld !== 1'b0 || din_rdy !== 1'b1) begin n_errors++; $display("FAIL bp_release vld %b rdy %b exp 0 1", dout_vld, din_rdy); end
    @(negedge clk);
    n_checks++; if (dout_vld !== 1'b1 || dout !== 24'h000009 || dout_cnt !== 8'd1) begin n_errors++; $display("FAIL bp_next vld %b dout %h cnt %0d exp 1 000009 1", dout_vld, dout, dout_cnt); end
    din_vld = 1'b0; din_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear;
    dout_rdy = 1'b1;
    beat(16'h0010, 1'b0);
    beat(16'h0020, 1'b0);
    clr = 1'b1; din = 16'h0040; din_vld = 1'b1; din_last = 1'b1;
    #1;
    n_checks++; if (din_rdy !== 1'b1) begin n_errors++; $display("FAIL clr_rdy got %b exp 1", din_rdy); end
    @(negedge clk);
    clr = 1'b0;
    n_checks++; if (dout_vld !== 1'b0) begin n_errors++; $display("FAIL clr_dropped vld got %b exp 0", dout_vld); end
    beat(16'h0005, 1'b1);
    n_checks++; if (dout !== 24'h000005 || dout_cnt !== 8'd1) begin n_errors++; $display("FAIL clr_next dout %h cnt %0d exp 000005 1", dout, dout_cnt); end
    din_vld = 1'b0; din_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    dout_rdy = 1'b1;
    beat(16'h0011, 1'b0);
    beat(16'h0022, 1'b0);
    din_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (dout !== 24'h0 || dout_cnt !== 8'h0 || dout_ovf !== 1'b0 || dout_vld !== 1'b0) begin n_errors++; $display("FAIL rst_mid outs dout %h cnt %0d ovf %b vld %b exp 0", dout, dout_cnt, dout_ovf, dout_vld); end
    n_checks++; if (din_rdy !== 1'b1) begin n_errors++; $display("FAIL rst_mid_rdy got %b exp 1", din_rdy); end
    @(negedge clk);
    rst_n = 1'b1;
    beat(16'h0007, 1'b1);
    n_checks++; if (dout !== 24'h000007 || dout_cnt !== 8'd1 || dout_vld !== 1'b1) begin n_errors++; $display("FAIL rst_next dout %h cnt %0d vld %b exp 000007 1 1", dout, dout_cnt, dout_vld); end
    din_vld = 1'b0; din_last = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; din = '0; din_vld = 1'b0; din_last = 1'b0; dout_rdy = 1'b0;
    b_clr = 1'b0; b_din = '0; b_vld = 1'b0; b_last = 1'b0; b_drdy = 1'b1;
    test_reset;
    test_basic_sum;
    test_single_beat;
    test_overflow;
    test_back_pressure;
    test_clear;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
